// File: rtl/load_fifo.sv
// Small synchronous FIFO that feeds a downstream load register: the head word and its
// load strobe are presented combinationally from state, so a word is visible one edge after push.
module load_fifo #(
  parameter int LSIZE = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LSIZE-1:0] d_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [LSIZE-1:0] d_o,
  output logic             ld_o,
  input  logic             ack_i,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [LSIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Handshakes depend only on occupancy, so a full FIFO never accepts on the same edge it pops.
  assign ready_o = (count_q != FullCount);
  assign ld_o    = (count_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = ld_o & ack_i;
  assign count_o = count_q;
  assign d_o     = ld_o ? mem_q[rdPtr_q] : '0;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; ld_o masks stale entries on d_o.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= d_i;
  end

endmodule

// File: doc/load_fifo.md
LOAD_FIFO -- requirements
Module: load_fifo

Interface
REQ-001 The block SHALL have parameter LSIZE, default 8, data word width in bits; it matches the width of the downstream register.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of storage entries; power of two, >= 2.
REQ-003 The block SHALL have port clk_i, input, 1, single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port d_i, input, LSIZE, upstream write data.
REQ-006 The block SHALL have port valid_i, input, 1, upstream offers d_i this cycle.
REQ-007 The block SHALL have port ready_o, output, 1, block accepts d_i this cycle.
REQ-008 The block SHALL have port d_o, output, LSIZE, head word; connects to the downstream register d_i.
REQ-009 The block SHALL have port ld_o, output, 1, head word valid; connects to the downstream register ld_i.
REQ-010 The block SHALL have port ack_i, input, 1, downstream consumed d_o this cycle.
REQ-011 The block SHALL have port count_o, output, clog2(DEPTH+1), current occupancy, 0..DEPTH.

Function
REQ-012 push = valid_i & ready_o; pop = ld_o & ack_i; both SHALL be evaluated at the same rising edge.
REQ-013 ready_o SHALL equal (count_o != DEPTH), combinational from state only, with no dependence on ack_i (no full-bypass).
REQ-014 ld_o SHALL equal (count_o != 0).
REQ-015 d_o SHALL equal the storage entry at the read pointer when ld_o=1, and all-zeros when ld_o=0.
REQ-016 On push, d_i SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-017 On pop, the read pointer SHALL advance by 1 modulo DEPTH.
REQ-018 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated word.
REQ-019 count_o SHALL update +1 on push only, -1 on pop only, and stay unchanged on push&pop or on neither.
REQ-020 Latency: a word pushed into an empty FIFO at edge N SHALL appear on d_o with ld_o=1 immediately after edge N (zero-bubble, one-edge latency).
REQ-021 When full with valid_i=1 and ack_i=1 at the same edge: pop only; ready_o returns to 1 after that edge; the offered word SHALL remain held by upstream.
REQ-022 When empty with ack_i=1: no pop; count_o SHALL stay 0 and pointers SHALL not move.
REQ-023 When occupancy is between 1 and DEPTH-1 with push&pop at the same edge: throughput SHALL be 1 word/cycle and count_o SHALL be unchanged.
REQ-024 Output order SHALL be strictly FIFO, with no reordering and no data corruption on any push/pop interleaving.
REQ-025 ack_i while ld_o=0 and valid_i while ready_o=0 SHALL be ignored without error.

Reset
REQ-026 rst_ni=0 SHALL asynchronously clear the write pointer, read pointer and count_o to 0, independent of clk_i.
REQ-027 During reset: ready_o=1, ld_o=0, d_o=0, count_o=0.
REQ-028 Storage contents SHALL not be cleared; after reset they SHALL never be observable because ld_o=0 masks d_o.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; the first push after release SHALL be the first word output.
REQ-030 Deassertion of rst_ni is synchronous to clk_i; the first push SHALL be honoured at the first rising edge after release.

Verification
REQ-031 Reset check: rst_ni=0 with random inputs -> ready_o=1, ld_o=0, d_o=0, count_o=0 throughout.
REQ-032 Fill to full: DEPTH=4, ack_i=0, push 0x11,0x22,0x33,0x44 -> count_o=4, ready_o=0, d_o=0x11; a fifth push of 0x55 is ignored.
REQ-033 Drain and wrap: after the fill, ack_i=1 for 4 cycles -> d_o sequence 0x11,0x22,0x33,0x44, then ld_o=0, d_o=0; push 0xA0..0xA5 while popping -> output 0xA0..0xA5 in order across the pointer wrap.
REQ-034 Streaming: valid_i=1 and ack_i=1 every cycle, d_i incrementing from 0 -> after the first word, d_o increments by 1 each cycle; count_o stays 1; no gaps.
REQ-035 Simultaneous events: full with valid_i=1, ack_i=1 -> count_o 4 to 3, and the offered word is not written that edge; empty with ack_i=1 -> count_o stays 0.
REQ-036 Reset mid-operation: count_o=3, assert rst_ni=0 between edges -> outputs clear immediately; after release, push 0x7E -> d_o=0x7E, count_o=1.
